// File: rtl/mii_frame_gen.sv
// Transmit-side MII frame generator: start word, seeded byte-counter payload, terminate, gap.
// Optional macro MII_ERR_INJECT_EN replaces the first post-start lane0 byte with /E/.
module mii_frame_gen #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned IFG_WORDS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [LEN_W-1:0]        len_in,
    input  logic [7:0]              seed_in,
    input  logic                    err_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [DATA_WIDTH/8-1:0] ctrl_out,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int unsigned LANES = DATA_WIDTH / 8;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_PRE   = 8'h55;
    localparam logic [7:0] CH_SFD   = 8'hD5;

    // GAP holds IFG_WORDS-1 idles; the IDLE cycle that can accept the next request
    // supplies the final gap word, so back-to-back frames see exactly IFG_WORDS idles.
    localparam int unsigned GAP_W = (IFG_WORDS > 2) ? $clog2(IFG_WORDS) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IFG_WORDS >= 2) ? IFG_WORDS - 2 : 0);

    if (DATA_WIDTH != 64) begin : g_bad_width
        $error("mii_frame_gen supports DATA_WIDTH=64 only");
    end
    if (IFG_WORDS < 1) begin : g_bad_ifg
        $error("mii_frame_gen requires IFG_WORDS >= 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StPayload,
        StLast,
        StGap
    } state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0]        rem_q, rem_d;
    logic [7:0]              byte_q, byte_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [LANES-1:0]        ctrl_q, ctrl_d;
    logic                    ready_q, busy_q, done_q;
    logic                    transfer;
    logic                    inject;
    logic [2:0]              last_r;

    assign transfer = start_valid & ready_q;
    assign last_r   = rem_q[2:0];

`ifdef MII_ERR_INJECT_EN
    logic err_q, err_d;
    logic first_q, first_d;

    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (state_q == StIdle && transfer) begin
            err_d   = err_in;
            first_d = 1'b1;
        end else if (state_q == StPayload || state_q == StLast) begin
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    // No /E/ when lane0 of that word carries /T/ (len=0).
    assign inject = err_q & first_q &
                    ((state_q == StPayload) || (state_q == StLast && last_r != 3'd0));
`else
    logic unused_err_in;
    assign unused_err_in = err_in;
    assign inject        = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    rem_d   = len_in;
                    byte_d  = seed_in;
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = (rem_q >= LEN_W'(8)) ? StPayload : StLast;
            end
            StPayload: begin
                rem_d  = rem_q - LEN_W'(8);
                byte_d = byte_q + 8'd8;
                if (rem_d < LEN_W'(8)) begin
                    state_d = StLast;
                end
            end
            StLast: begin
                if (IFG_WORDS > 1) begin
                    gap_d   = GAP_LOAD;
                    state_d = StGap;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Word for the current state; registered so it appears one cycle later.
    always_comb begin
        data_d = {LANES{CH_IDLE}};
        ctrl_d = '1;
        unique case (state_q)
            StStart: begin
                for (int i = 0; i < int'(LANES); i++) begin
                    data_d[8*i +: 8] = CH_PRE;
                end
                data_d[7:0]                    = CH_START;
                data_d[8*(LANES-1) +: 8]       = CH_SFD;
                ctrl_d                         = '0;
                ctrl_d[0]                      = 1'b1;
            end
            StPayload: begin
                for (int i = 0; i < int'(LANES); i++) begin
                    data_d[8*i +: 8] = byte_q + 8'(i);
                end
                ctrl_d = '0;
            end
            StLast: begin
                for (int i = 0; i < int'(LANES); i++) begin
                    if (i < int'(last_r)) begin
                        data_d[8*i +: 8] = byte_q + 8'(i);
                        ctrl_d[i]        = 1'b0;
                    end else if (i == int'(last_r)) begin
                        data_d[8*i +: 8] = CH_TERM;
                        ctrl_d[i]        = 1'b1;
                    end else begin
                        data_d[8*i +: 8] = CH_IDLE;
                        ctrl_d[i]        = 1'b1;
                    end
                end
            end
            default: begin
                data_d = {LANES{CH_IDLE}};
                ctrl_d = '1;
            end
        endcase
        if (inject) begin
            data_d[7:0] = 8'hFE;
            ctrl_d[0]   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            byte_q  <= '0;
            gap_q   <= '0;
            data_q  <= {LANES{CH_IDLE}};
            ctrl_q  <= '1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            ready_q <= (state_d == StIdle);
            busy_q  <= (state_d != StIdle) || (state_q != StIdle);
            done_q  <= (state_q == StLast);
        end
    end

    assign data_out    = data_q;
    assign ctrl_out    = ctrl_q;
    assign start_ready = ready_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;

endmodule
